// File: rtl/dec_dispatch_ctrl.sv
// Dispatch scheduler: accepts decode ways in program order into two RSs,
// tracking free entries with credits and halting on illegal instructions.
module dec_dispatch_ctrl #(
    parameter int RS0_DEPTH = 8,
    parameter int RS1_DEPTH = 8,
    localparam int CW = $clog2((RS0_DEPTH > RS1_DEPTH ? RS0_DEPTH : RS1_DEPTH) + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1:0]    dec_valid_i,
    input  logic [1:0]    dec_rs_id_i,
    input  logic [1:0]    dec_illegal_i,
    output logic [1:0]    dec_accept_o,
    input  logic [1:0]    rs0_ret_i,
    input  logic [1:0]    rs1_ret_i,
    input  logic          flush_i,
    output logic [1:0]    disp_valid_o,
    output logic [1:0]    disp_rs_id_o,
    output logic          exc_valid_o,
    output logic          exc_way_o,
    output logic [CW-1:0] rs0_credit_o,
    output logic [CW-1:0] rs1_credit_o,
    output logic [31:0]   stall_cnt_o
);

    localparam int RW = CW + 2;
    localparam logic signed [RW-1:0] MAX0 = RW'(RS0_DEPTH);
    localparam logic signed [RW-1:0] MAX1 = RW'(RS1_DEPTH);

    typedef enum logic {RUN, EXC} state_t;

    state_t state, state_next;
    logic a0, a1, hit, hit_way;
    logic [CW-1:0] cr_w0, cr_w1;
    logic [1:0] use0, use1;
    logic signed [RW-1:0] raw0, raw1;
    logic [CW-1:0] next0, next1;

    assign cr_w0 = dec_rs_id_i[0] ? rs1_credit_o : rs0_credit_o;
    assign cr_w1 = dec_rs_id_i[1] ? rs1_credit_o : rs0_credit_o;

    always_comb begin
        state_next = state;
        a0 = 1'b0;
        a1 = 1'b0;
        hit = 1'b0;
        hit_way = 1'b0;
        if (flush_i) begin
            state_next = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    a0 = dec_valid_i[0] & ~dec_illegal_i[0] & (cr_w0 >= CW'(1));
                    // way1 sees one fewer credit when it shares way0's RS
                    a1 = a0 & dec_valid_i[1] & ~dec_illegal_i[1] &
                         (cr_w1 >= ((dec_rs_id_i[1] == dec_rs_id_i[0]) ? CW'(2) : CW'(1)));
                    if (dec_valid_i[0] & dec_illegal_i[0]) begin
                        hit = 1'b1;
                    end else if (a0 & dec_valid_i[1] & dec_illegal_i[1]) begin
                        hit = 1'b1;
                        hit_way = 1'b1;
                    end
                    if (hit) state_next = EXC;
                end
                EXC: ;
                default: state_next = RUN;
            endcase
        end
    end

    assign dec_accept_o = {a1, a0};

    assign use0 = {1'b0, a0 & ~dec_rs_id_i[0]} + {1'b0, a1 & ~dec_rs_id_i[1]};
    assign use1 = {1'b0, a0 & dec_rs_id_i[0]} + {1'b0, a1 & dec_rs_id_i[1]};

    assign raw0 = $signed({2'b00, rs0_credit_o}) + $signed({{CW{1'b0}}, rs0_ret_i})
                - $signed({{CW{1'b0}}, use0});
    assign raw1 = $signed({2'b00, rs1_credit_o}) + $signed({{CW{1'b0}}, rs1_ret_i})
                - $signed({{CW{1'b0}}, use1});

    always_comb begin
        next0 = raw0[CW-1:0];
        next1 = raw1[CW-1:0];
        if (raw0 < 0) next0 = '0;
        else if (raw0 > MAX0) next0 = CW'(RS0_DEPTH);
        if (raw1 < 0) next1 = '0;
        else if (raw1 > MAX1) next1 = CW'(RS1_DEPTH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            rs0_credit_o <= CW'(RS0_DEPTH);
            rs1_credit_o <= CW'(RS1_DEPTH);
            disp_valid_o <= '0;
            disp_rs_id_o <= '0;
            exc_valid_o  <= 1'b0;
            exc_way_o    <= 1'b0;
            stall_cnt_o  <= '0;
        end else begin
            state        <= state_next;
            disp_valid_o <= {a1, a0};
            disp_rs_id_o <= dec_rs_id_i;
            if (flush_i) begin
                rs0_credit_o <= CW'(RS0_DEPTH);
                rs1_credit_o <= CW'(RS1_DEPTH);
                exc_valid_o  <= 1'b0;
                exc_way_o    <= 1'b0;
            end else begin
                rs0_credit_o <= next0;
                rs1_credit_o <= next1;
                if (hit) begin
                    exc_valid_o <= 1'b1;
                    exc_way_o   <= hit_way;
                end
            end
            if (state == RUN && !flush_i && dec_valid_i[0] && !dec_illegal_i[0] &&
                !a0 && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end

    // Credits outside [0,DEPTH] mean the RS or upstream miscounted
    a_rs0_range: assert property (@(posedge clock) disable iff (!reset_n)
        flush_i || (raw0 >= 0 && raw0 <= MAX0));
    a_rs1_range: assert property (@(posedge clock) disable iff (!reset_n)
        flush_i || (raw1 >= 0 && raw1 <= MAX1));

endmodule
